mouse_accum: RTL



---
 rtl/mouse_accum.sv | 137 +++++++++++++
 1 files changed

// File: rtl/mouse_accum.sv
// mouse_accum: sums host mouse deltas into saturating per-axis accumulators and
// emits one clamped packet per frame, carrying unconsumed motion into later frames.
module mouse_accum #(
   parameter int ACC_W = 12
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        CE,
   input  logic [24:0] MOUSE_IN,
   input  logic        VBLANK,
   output logic [24:0] MOUSE_OUT
);
   localparam int SW = ACC_W + 2;

   typedef enum logic [1:0] {IDLE = 2'd0, PEND = 2'd1, EMIT = 2'd2} state_t;

   state_t                  state, state_next;
   logic signed [ACC_W-1:0] acc_x, acc_y, acc_x_next, acc_y_next;
   logic [2:0]              btn, btn_next, btn_sent, btn_sent_next;
   logic                    tog_q, vbl_q;
   logic [24:0]             out_next;
   logic                    pkt, rise, do_emit, pending_next;
   logic signed [SW-1:0]    dx, dy, ext_x, ext_y, ext_ex, ext_ey;
   logic signed [8:0]       ex, ey;
   logic                    unused_bits;

   assign unused_bits = MOUSE_IN[3];

   // 9-bit packet delta; the overflow flag forces the extreme value of the given sign
   function automatic logic signed [SW-1:0] axis_delta(input logic sgn, input logic [7:0] lo,
                                                        input logic ovf);
      logic [8:0] d;
      if (ovf) begin
         d = sgn ? 9'h100 : 9'h0FF;
      end else begin
         d = {sgn, lo};
      end
      return {{(SW-9){d[8]}}, d};
   endfunction

   function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [SW-1:0] v);
      logic signed [SW-1:0] hi, lo;
      hi = {3'b000, {(ACC_W-1){1'b1}}};
      lo = {3'b111, {(ACC_W-1){1'b0}}};
      if (v > hi) begin
         return hi[ACC_W-1:0];
      end else if (v < lo) begin
         return lo[ACC_W-1:0];
      end else begin
         return v[ACC_W-1:0];
      end
   endfunction

   function automatic logic signed [8:0] clamp_emit(input logic signed [ACC_W-1:0] a);
      logic signed [ACC_W-1:0] hi, lo;
      hi = {{(ACC_W-8){1'b0}}, 8'hFF};
      lo = {{(ACC_W-8){1'b1}}, 8'h00};
      if (a > hi) begin
         return 9'h0FF;
      end else if (a < lo) begin
         return 9'h100;
      end else begin
         return a[8:0];
      end
   endfunction

   // Intake, emission arithmetic and next-state selection
   always_comb begin
      pkt     = MOUSE_IN[24] ^ tog_q;
      rise    = CE & VBLANK & ~vbl_q;
      do_emit = (state == PEND) & rise;
      ex      = clamp_emit(acc_x);
      ey      = clamp_emit(acc_y);
      ext_x   = {{2{acc_x[ACC_W-1]}}, acc_x};
      ext_y   = {{2{acc_y[ACC_W-1]}}, acc_y};
      ext_ex  = {{(SW-9){ex[8]}}, ex};
      ext_ey  = {{(SW-9){ey[8]}}, ey};

      if (pkt) begin
         dx       = axis_delta(MOUSE_IN[4], MOUSE_IN[15:8], MOUSE_IN[6]);
         dy       = axis_delta(MOUSE_IN[5], MOUSE_IN[23:16], MOUSE_IN[7]);
         btn_next = MOUSE_IN[2:0];
      end else begin
         dx       = {SW{1'b0}};
         dy       = {SW{1'b0}};
         btn_next = btn;
      end

      // Emission uses the pre-update accumulators and buttons
      if (do_emit) begin
         acc_x_next    = sat_acc(ext_x - ext_ex + dx);
         acc_y_next    = sat_acc(ext_y - ext_ey + dy);
         btn_sent_next = btn;
         out_next      = {~MOUSE_OUT[24], ey[7:0], ex[7:0], (ext_y != ext_ey), (ext_x != ext_ex),
                          ey[8], ex[8], 1'b0, btn};
      end else begin
         acc_x_next    = sat_acc(ext_x + dx);
         acc_y_next    = sat_acc(ext_y + dy);
         btn_sent_next = btn_sent;
         out_next      = MOUSE_OUT;
      end

      pending_next = (acc_x_next != {ACC_W{1'b0}}) | (acc_y_next != {ACC_W{1'b0}})
                   | (btn_next != btn_sent_next);

      state_next = IDLE;
      case (state)
         IDLE:    state_next = pending_next ? PEND : IDLE;
         PEND:    state_next = do_emit ? EMIT : (pending_next ? PEND : IDLE);
         EMIT:    state_next = pending_next ? PEND : IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State, accumulators and the registered output packet
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state     <= IDLE;
         acc_x     <= {ACC_W{1'b0}};
         acc_y     <= {ACC_W{1'b0}};
         btn       <= 3'b000;
         btn_sent  <= 3'b000;
         tog_q     <= 1'b0;
         vbl_q     <= 1'b0;
         MOUSE_OUT <= 25'h0;
      end else begin
         state     <= state_next;
         acc_x     <= acc_x_next;
         acc_y     <= acc_y_next;
         btn       <= btn_next;
         btn_sent  <= btn_sent_next;
         tog_q     <= MOUSE_IN[24];
         vbl_q     <= CE ? VBLANK : vbl_q;
         MOUSE_OUT <= out_next;
      end
   end
endmodule
